// File: rtl/config_pkg.sv
// Shared types for the ternary matmul AFU: vector geometry, DDR port widths and instruction format.
package config_pkg;

    parameter int D = 4;

    typedef logic [7:0]  fixed_point_t;
    typedef logic [15:0] ddr_address_t;
    typedef logic [7:0]  ddr_data_t;
    typedef logic [4:0]  v_addr_t;

    typedef enum logic [1:0] {
        LOAD_STORE = 2'd0,
        TMATMUL    = 2'd1,
        VECTOR_ALU = 2'd2,
        CONTROL    = 2'd3
    } fu_t;

    typedef enum logic [1:0] {
        LS_NOP  = 2'd0,
        LDV     = 2'd1,
        SV      = 2'd2,
        LS_RSVD = 2'd3
    } load_store_op_t;

    typedef struct packed {
        fu_t            fu;
        load_store_op_t load_store_operation;
        v_addr_t        v_a;
        v_addr_t        v_y;
        ddr_address_t   ddr_address;
    } instruction_t;

endpackage

// File: rtl/vector_load_store_unit.sv
// Vector load/store unit: gathers D DDR bytes into a vector register (LDV) or scatters one out (SV).
// Optional macro LSU_ADDR_RANGE_CHECK_EN rejects transfers that would wrap past 16'hFFFF.
module vector_load_store_unit
    import config_pkg::*;
#(
    parameter int D = config_pkg::D
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   instr_valid_i,
    output logic                   instr_ready_o,
    input  instruction_t           instr_i,
    output logic                   ddr_req_o,
    output logic                   ddr_we_o,
    output ddr_address_t           ddr_addr_o,
    output ddr_data_t              ddr_wdata_o,
    input  logic                   ddr_gnt_i,
    input  logic                   ddr_rvalid_i,
    input  ddr_data_t              ddr_rdata_i,
    output v_addr_t                vrf_raddr_o,
    input  fixed_point_t [D-1:0]   vrf_rdata_i,
    output logic                   vrf_we_o,
    output v_addr_t                vrf_waddr_o,
    output fixed_point_t [D-1:0]   vrf_wdata_o,
    output logic                   done_o,
    output logic                   err_o
);

    localparam int IDX_W = (D > 1) ? $clog2(D) : 1;

    typedef enum logic [2:0] {
        IDLE, LD_REQ, LD_WAIT, LD_WRITE, ST_REQ, DONE
    } state_t;

    state_t               state_q;
    logic [IDX_W-1:0]     idx_q;
    fixed_point_t [D-1:0] buf_q;
    ddr_address_t         addr_q;
    v_addr_t              v_y_q;
    logic                 err_q;

    ddr_address_t         ddr_addr_d;
    logic                 idx_last;
    logic                 range_ok;
    logic                 instr_legal;

    always_comb begin
        // NOTE: every signal gets a default first so no path through this block infers a latch.
        range_ok    = 1'b1;
`ifdef LSU_ADDR_RANGE_CHECK_EN
        range_ok    = ({1'b0, instr_i.ddr_address} + 17'(D - 1)) <= 17'h0_FFFF;
`endif
        instr_legal = (instr_i.fu == LOAD_STORE) && range_ok &&
                      ((instr_i.load_store_operation == LDV) ||
                       (instr_i.load_store_operation == SV));
        ddr_addr_d  = addr_q + ddr_address_t'(idx_q);
        idx_last    = (idx_q == IDX_W'(D - 1));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            // NOTE: the element buffer is small and observable on vrf_wdata_o, so it is reset like any register.
            buf_q   <= '0;
            addr_q  <= '0;
            v_y_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (instr_valid_i) begin
                        addr_q <= instr_i.ddr_address;
                        v_y_q  <= instr_i.v_y;
                        idx_q  <= '0;
                        if (!instr_legal) begin
                            err_q   <= 1'b1;
                            state_q <= DONE;
                        end else if (instr_i.load_store_operation == SV) begin
                            buf_q   <= vrf_rdata_i;
                            state_q <= ST_REQ;
                        end else begin
                            state_q <= LD_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (ddr_gnt_i) begin
                        idx_q   <= idx_last ? '0 : idx_q + IDX_W'(1);
                        state_q <= idx_last ? DONE : ST_REQ;
                    end
                end
                LD_REQ: begin
                    if (ddr_gnt_i) begin
                        state_q <= LD_WAIT;
                    end
                end
                LD_WAIT: begin
                    // Read data is only accepted here; a stray rvalid in any other state is dropped.
                    if (ddr_rvalid_i) begin
                        buf_q[idx_q] <= ddr_rdata_i;
                        idx_q        <= idx_last ? '0 : idx_q + IDX_W'(1);
                        state_q      <= idx_last ? LD_WRITE : LD_REQ;
                    end
                end
                LD_WRITE: state_q <= DONE;
                DONE: begin
                    err_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        instr_ready_o = (state_q == IDLE);
        vrf_raddr_o   = (state_q == IDLE) ? instr_i.v_a : '0;
        ddr_req_o     = (state_q == ST_REQ) || (state_q == LD_REQ);
        ddr_we_o      = (state_q == ST_REQ);
        ddr_addr_o    = ddr_req_o ? ddr_addr_d : '0;
        ddr_wdata_o   = (state_q == ST_REQ) ? buf_q[idx_q] : '0;
        vrf_we_o      = (state_q == LD_WRITE);
        vrf_waddr_o   = vrf_we_o ? v_y_q : '0;
        vrf_wdata_o   = vrf_we_o ? buf_q : '0;
        done_o        = (state_q == DONE);
        err_o         = done_o && err_q;
    end

endmodule

// File: tb/tb_vector_load_store_unit.sv
// Scoreboard bench for vector_load_store_unit: directed SV/LDV/error/wrap/reset scenarios
// with a small DDR and VRF model; honours LSU_ADDR_RANGE_CHECK_EN for the wrap case.
module tb_vector_load_store_unit;
    import config_pkg::*;

    localparam int D = config_pkg::D;

    logic                 clk_i = 1'b0;
    logic                 rst_i = 1'b1;
    logic                 instr_valid_i = 1'b0;
    logic                 instr_ready_o;
    instruction_t         instr_i = '0;
    logic                 ddr_req_o;
    logic                 ddr_we_o;
    ddr_address_t         ddr_addr_o;
    ddr_data_t            ddr_wdata_o;
    logic                 ddr_gnt_i = 1'b1;
    logic                 ddr_rvalid_i = 1'b0;
    ddr_data_t            ddr_rdata_i = '0;
    v_addr_t              vrf_raddr_o;
    fixed_point_t [D-1:0] vrf_rdata_i;
    logic                 vrf_we_o;
    v_addr_t              vrf_waddr_o;
    fixed_point_t [D-1:0] vrf_wdata_o;
    logic                 done_o;
    logic                 err_o;

    typedef enum logic [1:0] {EV_RD, EV_WR, EV_VRF, EV_DONE} ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        logic [15:0] a;
        logic [31:0] d;
        int          cyc;
    } ev_t;

    ev_t                  exp_q[$];
    int                   n_cmp = 0;
    int                   n_fail = 0;
    int                   cyc = 0;
    int                   n_vrf_ev = 0;
    int                   n_done_ev = 0;
    int                   rd_lat = 1;
    bit                   gnt_rand = 1'b0;
    bit [7:0]             mem [65536];
    fixed_point_t [D-1:0] vrf [32];

    assign vrf_rdata_i = vrf[vrf_raddr_o];

    vector_load_store_unit dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .instr_valid_i(instr_valid_i),
        .instr_ready_o(instr_ready_o),
        .instr_i      (instr_i),
        .ddr_req_o    (ddr_req_o),
        .ddr_we_o     (ddr_we_o),
        .ddr_addr_o   (ddr_addr_o),
        .ddr_wdata_o  (ddr_wdata_o),
        .ddr_gnt_i    (ddr_gnt_i),
        .ddr_rvalid_i (ddr_rvalid_i),
        .ddr_rdata_i  (ddr_rdata_i),
        .vrf_raddr_o  (vrf_raddr_o),
        .vrf_rdata_i  (vrf_rdata_i),
        .vrf_we_o     (vrf_we_o),
        .vrf_waddr_o  (vrf_waddr_o),
        .vrf_wdata_o  (vrf_wdata_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    initial forever #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input ev_kind_t kind, input logic [15:0] a, input logic [31:0] d, input int c);
        ev_t e;
        e.kind = kind;
        e.a    = a;
        e.d    = d;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic observe(input ev_kind_t kind, input logic [15:0] a, input logic [31:0] d);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d addr %0h data %0h expected none (cycle %0d)",
                     kind, a, d, cyc);
        end else begin
            e = exp_q.pop_front();
            check($sformatf("event_%0d", e.kind), {kind, a, d}, {e.kind, e.a, e.d});
            if (e.cyc >= 0) check($sformatf("event_%0d_cycle", e.kind), 64'(cyc), 64'(e.cyc));
        end
    endtask

    // Grant driver: tied high, or a coin flip each cycle to create stalls.
    initial forever begin
        @(posedge clk_i);
        #1;
        ddr_gnt_i = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Read responder: returns mem[addr] rd_lat cycles after each granted read.
    initial forever begin
        logic [15:0] a;
        @(negedge clk_i);
        if (!rst_i && ddr_req_o === 1'b1 && ddr_we_o === 1'b0 && ddr_gnt_i) begin
            a = ddr_addr_o;
            @(posedge clk_i);
            repeat (rd_lat - 1) @(posedge clk_i);
            #1;
            ddr_rvalid_i = 1'b1;
            ddr_rdata_i  = mem[a];
            @(posedge clk_i);
            #1;
            ddr_rvalid_i = 1'b0;
            ddr_rdata_i  = '0;
        end
    end

    // Monitor: turns DUT outputs into events and checks request stability during stalls.
    initial begin
        bit          prev_stall = 1'b0;
        logic        p_we = 1'b0;
        logic [15:0] p_addr = '0;
        logic [7:0]  p_wd = '0;
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall)
                    check("stall_hold", {ddr_req_o, ddr_we_o, ddr_addr_o, ddr_wdata_o},
                          {1'b1, p_we, p_addr, p_wd});
                prev_stall = (ddr_req_o === 1'b1) && !ddr_gnt_i;
                p_we       = ddr_we_o;
                p_addr     = ddr_addr_o;
                p_wd       = ddr_wdata_o;
                if (ddr_req_o === 1'b1 && ddr_gnt_i)
                    observe(ddr_we_o ? EV_WR : EV_RD, ddr_addr_o, ddr_we_o ? 32'(ddr_wdata_o) : 32'h0);
                if (vrf_we_o === 1'b1) begin
                    n_vrf_ev++;
                    observe(EV_VRF, 16'(vrf_waddr_o), 32'(vrf_wdata_o));
                end
                if (done_o === 1'b1) begin
                    n_done_ev++;
                    observe(EV_DONE, 16'h0, 32'(err_o));
                end
            end
        end
    end

    task automatic issue(input fu_t fu, input load_store_op_t op, input v_addr_t va, input v_addr_t vy,
                         input logic [15:0] addr, output int t);
        for (int i = 0; i < 50 && instr_ready_o !== 1'b1; i++) begin
            @(posedge clk_i);
            #1;
        end
        check("ready_before_issue", 64'(instr_ready_o), 64'd1);
        instr_i.fu                   = fu;
        instr_i.load_store_operation = op;
        instr_i.v_a                  = va;
        instr_i.v_y                  = vy;
        instr_i.ddr_address          = addr;
        instr_valid_i                = 1'b1;
        t                            = cyc;
    endtask

    task automatic release_instr();
        @(posedge clk_i);
        #1;
        instr_valid_i = 1'b0;
        instr_i       = '0;
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clk_i);
        #1;
        check("drain_pending", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        n_fail++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        int vrf_snap;
        int done_snap;
        logic [7:0] ld_bytes [4];
        logic [7:0] wrap_bytes [4];

        for (int i = 0; i < 32; i++) vrf[i] = '0;
        vrf[2] = 32'h0403_0201;
        vrf[5] = 32'hDEAD_BEEF;
        ld_bytes   = '{8'h80, 8'h7F, 8'hFF, 8'h00};
        wrap_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            mem[16'h0200 + i]        = ld_bytes[i];
            mem[16'(16'hFFFE + i)]   = wrap_bytes[i];
        end

        repeat (3) @(posedge clk_i);
        #1;
        check("reset_ready", 64'(instr_ready_o), 64'd1);
        check("reset_outputs", {ddr_req_o, ddr_we_o, vrf_we_o, done_o, err_o}, 64'd0);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;

        // SV from reg2 to 0x0100 with gnt tied high.
        issue(LOAD_STORE, SV, 5'd2, 5'd0, 16'h0100, t);
        for (int i = 0; i < 4; i++) push(EV_WR, 16'h0100 + 16'(i), 32'(i + 1), t + 1 + i);
        push(EV_DONE, 16'h0, 32'd0, t + 5);
        release_instr();
        drain();

        // LDV into reg1 from 0x0200, read latency 3.
        rd_lat = 3;
        issue(LOAD_STORE, LDV, 5'd0, 5'd1, 16'h0200, t);
        for (int i = 0; i < 4; i++) push(EV_RD, 16'h0200 + 16'(i), 32'h0, t + 1 + 4 * i);
        push(EV_VRF, 16'd1, 32'h00FF_7F80, t + 17);
        push(EV_DONE, 16'h0, 32'd0, t + 18);
        release_instr();
        drain();

        // SV from reg5 to 0x3000 under random grant stalls.
        gnt_rand = 1'b1;
        issue(LOAD_STORE, SV, 5'd5, 5'd0, 16'h3000, t);
        push(EV_WR, 16'h3000, 32'hEF, -1);
        push(EV_WR, 16'h3001, 32'hBE, -1);
        push(EV_WR, 16'h3002, 32'hAD, -1);
        push(EV_WR, 16'h3003, 32'hDE, -1);
        push(EV_DONE, 16'h0, 32'd0, -1);
        release_instr();
        drain();
        gnt_rand = 1'b0;
        @(posedge clk_i);
        #1;

        // Wrong functional unit and unsupported operation both retire as errors.
        issue(TMATMUL, LDV, 5'd1, 5'd1, 16'h0000, t);
        push(EV_DONE, 16'h0, 32'd1, t + 1);
        release_instr();
        drain();
        issue(LOAD_STORE, LS_NOP, 5'd1, 5'd1, 16'h0010, t);
        push(EV_DONE, 16'h0, 32'd1, t + 1);
        release_instr();
        drain();

        // LDV crossing the top of the address space.
        rd_lat = 1;
        issue(LOAD_STORE, LDV, 5'd0, 5'd7, 16'hFFFE, t);
`ifdef LSU_ADDR_RANGE_CHECK_EN
        push(EV_DONE, 16'h0, 32'd1, t + 1);
`else
        for (int i = 0; i < 4; i++) push(EV_RD, 16'(16'hFFFE + i), 32'h0, t + 1 + 2 * i);
        push(EV_VRF, 16'd7, 32'h4433_2211, t + 9);
        push(EV_DONE, 16'h0, 32'd0, t + 10);
`endif
        release_instr();
        drain();

        // Reset while waiting for read data; the late rvalid must be ignored.
        rd_lat = 3;
        issue(LOAD_STORE, LDV, 5'd0, 5'd3, 16'h0400, t);
        push(EV_RD, 16'h0400, 32'h0, t + 1);
        release_instr();
        @(posedge clk_i);
        #1;
        vrf_snap  = n_vrf_ev;
        done_snap = n_done_ev;
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        check("ready_after_reset", 64'(instr_ready_o), 64'd1);
        check("pending_after_reset", 64'(exp_q.size()), 64'd0);
        repeat (10) @(posedge clk_i);
        #1;
        check("no_vrf_write_after_reset", 64'(n_vrf_ev - vrf_snap), 64'd0);
        check("no_done_after_reset", 64'(n_done_ev - done_snap), 64'd0);

        // Unit is usable again after the abandoned load.
        rd_lat = 1;
        issue(LOAD_STORE, SV, 5'd2, 5'd0, 16'h0500, t);
        for (int i = 0; i < 4; i++) push(EV_WR, 16'h0500 + 16'(i), 32'(i + 1), t + 1 + i);
        push(EV_DONE, 16'h0, 32'd0, t + 5);
        release_instr();
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/vector_load_store_unit.md
# vector_load_store_unit

Load/store functional unit for the ternary matmul AFU. It executes `LOAD_STORE` instructions issued by the instruction sequencer. `LDV` gathers `D` consecutive DDR bytes into a vector register. `SV` scatters a vector register to `D` consecutive DDR bytes. The unit sits between the instruction issue stage, the vector register file and the DDR request port, and runs one instruction at a time.

## Interface
Parameters come from `config_pkg`: `D` = 4, `fixed_point_t` = 8 bits, `ddr_address_t` = 16 bits, `ddr_data_t` = 8 bits, `v_addr_t`, `instruction_t`. Local parameters:
- `D` — default `config_pkg::D` — number of elements per vector, one DDR byte per element.

Ports (one clock; reset is synchronous and active-high):
- `clk_i` — in — 1 — clock; all state changes on the rising edge.
- `rst_i` — in — 1 — synchronous, active-high reset.
- `instr_valid_i` — in — 1 — instruction offered.
- `instr_ready_o` — out — 1 — unit can accept an instruction.
- `instr_i` — in — `instruction_t` — uses `fu`, `load_store_operation`, `v_a` (SV source), `v_y` (LDV destination), `ddr_address`.
- `ddr_req_o` — out — 1 — DDR request.
- `ddr_we_o` — out — 1 — 1 = write, 0 = read.
- `ddr_addr_o` — out — 16 — byte address.
- `ddr_wdata_o` — out — 8 — write data.
- `ddr_gnt_i` — in — 1 — request accepted this cycle.
- `ddr_rvalid_i` — in — 1 — read data valid.
- `ddr_rdata_i` — in — 8 — read data.
- `vrf_raddr_o` — out — `v_addr_t` — vector register file read address.
- `vrf_rdata_i` — in — `D`×`fixed_point_t` — combinational read data; element i at bits [8i+7:8i].
- `vrf_we_o` — out — 1 — vector register file write strobe, one cycle.
- `vrf_waddr_o` — out — `v_addr_t` — write address.
- `vrf_wdata_o` — out — `D`×`fixed_point_t` — write data, same packing as `vrf_rdata_i`.
- `done_o` — out — 1 — one-cycle pulse when the instruction retires.
- `err_o` — out — 1 — qualifies `done_o`; the instruction was rejected.

## Operation
- FSM states: `IDLE`, `LD_REQ`, `LD_WAIT`, `LD_WRITE`, `ST_REQ`, `DONE`.
- `IDLE`: `instr_ready_o`=1 and `vrf_raddr_o`=`instr_i.v_a`. An instruction is accepted when valid && ready. On accept, latch the address and `v_y`.
- Dispatch on accept:
  - `fu`≠`LOAD_STORE`, or operation not `LDV`/`SV`: go to `DONE` with `err_o`=1. No DDR or VRF activity.
  - `SV`: snapshot `vrf_rdata_i` into the element buffer, then go to `ST_REQ`.
  - `LDV`: go to `LD_REQ`.
- Element counter `idx` runs 0..D-1. Element `idx` uses address `ddr_address + idx`, computed modulo 2^16.
- `ST_REQ`: `ddr_req_o`=1, `ddr_we_o`=1, `ddr_wdata_o`=buffer[idx]. Request fields stay stable until `ddr_gnt_i`. On gnt, `idx`++. After the gnt for idx=D-1, go to `DONE`.
- `LD_REQ`: `ddr_req_o`=1, `ddr_we_o`=0. On gnt, go to `LD_WAIT`. Only one read is outstanding at a time.
- `LD_WAIT`: on `ddr_rvalid_i`, buffer[idx]=`ddr_rdata_i`. Then go to `LD_REQ` with `idx`++, or to `LD_WRITE` if idx=D-1. Any `rvalid` seen outside `LD_WAIT` is ignored.
- `LD_WRITE`: `vrf_we_o`=1 for one cycle with `vrf_waddr_o`=latched `v_y` and `vrf_wdata_o`=buffer. Then go to `DONE`.
- `DONE`: `done_o`=1 for one cycle, with `err_o` as decided at dispatch. Then go to `IDLE`.

## Timing
- Reset values: state `IDLE`, `idx`=0, buffer=0. `instr_ready_o`=1. All other outputs 0.
- Reset mid-operation abandons the transfer: no VRF write, no `done_o`. A late `rvalid` after reset is ignored.
- `ddr_req_o` never asserts in the accept cycle T.
- Store latency with gnt tied high: requests at T+1..T+D, `done_o` at T+D+1.
- Load latency with gnt tied high and rvalid one cycle after gnt: request for element i at T+1+2i, rvalid at T+2+2i, `vrf_we_o` at T+2D+1, `done_o` at T+2D+2.
- Error instruction: `done_o`=`err_o`=1 at T+1.
- Next accept is possible at the cycle after `done_o`.
- Gnt stalls extend the current state indefinitely; the request stays held.

## Configuration
- `LSU_ADDR_RANGE_CHECK_EN` defined: an `LDV`/`SV` with `ddr_address + D - 1 > 16'hFFFF` is rejected as an error instruction (no DDR access).
- Not defined: the address wraps modulo 2^16 (element after `16'hFFFF` goes to `16'h0000`).

## Test plan
- SV, `v_a`=2, VRF reg2 = {8'h04,8'h03,8'h02,8'h01}, addr 16'h0100, gnt=1 -> writes 01,02,03,04 to 0x0100..0x0103 on T+1..T+4; `done_o` at T+5, `err_o`=0.
- LDV, `v_y`=1, addr 16'h0200, DDR holds 0x80,0x7F,0xFF,0x00, rvalid latency 3 -> one `vrf_we_o` with waddr 1 and wdata {00,FF,7F,80}; `done_o` next cycle.
- Random gnt stalls during SV -> address and data held stable until gnt; no skipped or duplicated element.
- `fu`=`TMATMUL` offered -> accepted, `done_o`=`err_o`=1 at T+1, no `ddr_req_o`.
- LDV at 16'hFFFE -> with macro: error at T+1. Without macro: reads 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- `rst_i` pulsed during `LD_WAIT`, then a stray `rvalid` -> no `vrf_we_o` and no `done_o`; `instr_ready_o`=1 the cycle after reset.
